// File: rtl/fp_add_normalize_if.sv
// Operand/result bundle between the alignment stage, the add/normalize stage and its consumer.
interface fp_add_normalize_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  localparam int MAN_W = FRAC_W + 5;
  localparam int RES_W = 1 + EXP_W + FRAC_W;

  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic             sign_in;
  logic [EXP_W-1:0] exp;
  logic [MAN_W-1:0] mantis_great;
  logic [MAN_W-1:0] mantis_small;
  logic             is_special;
  logic [RES_W-1:0] special_result;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] result;
  logic             overflow;
  logic             underflow;

  modport master (
    output in_valid, op_sub, sign_in, exp, mantis_great, mantis_small,
           is_special, special_result, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, op_sub, sign_in, exp, mantis_great, mantis_small,
           is_special, special_result, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );
endinterface

// File: rtl/fp_add_normalize.sv
// fp_add_normalize: add/sub aligned mantissas, normalize, round-to-nearest-even, pack; LZC_NORM_EN selects one-cycle normalize.
// Latency 4+k cycles (k left shifts; fixed 4 with LZC_NORM_EN; specials 1); one op in flight, result held until out_ready.
module fp_add_normalize #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_add_normalize_if.slave bus
);
  localparam int MAN_W = FRAC_W + 5;
  localparam int RES_W = 1 + EXP_W + FRAC_W;
  localparam int EW    = EXP_W + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SUM   = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [EW-1:0] EXP_ONE = EW'(1);
  localparam logic [EW-1:0] EXP_INF = {2'b00, {EXP_W{1'b1}}};

  logic [2:0]       r_state;
  logic             r_sub;
  logic             r_sign;
  logic [MAN_W-1:0] r_great;
  logic [MAN_W-1:0] r_small;
  logic [MAN_W-1:0] r_man;
  logic [EW-1:0]    r_exp;
  logic [RES_W-1:0] r_result;
  logic             r_ovf;
  logic             r_unf;

  // Rounded value laid out as {carry, hidden, fraction}.
  logic              w_inc;
  logic [FRAC_W+1:0] w_rnd;
  logic [EW-1:0]     w_exp_rnd;
  logic [FRAC_W-1:0] w_frac_rnd;

  assign w_inc = r_man[2] & (r_man[3] | r_man[1] | r_man[0]);
  assign w_rnd = {1'b0, r_man[MAN_W-2:3]} + {{(FRAC_W+1){1'b0}}, w_inc};

  always_comb begin
    w_exp_rnd  = r_exp;
    w_frac_rnd = w_rnd[FRAC_W-1:0];
    if (w_rnd[FRAC_W+1]) begin
      w_exp_rnd  = r_exp + EXP_ONE;
      w_frac_rnd = w_rnd[FRAC_W:1];
    end else if (!w_rnd[FRAC_W]) begin
      w_exp_rnd  = '0;
    end
  end

`ifdef LZC_NORM_EN
  logic [EW-1:0] w_lz;
  logic [EW-1:0] w_sh;

  // Highest set bit wins; shift is clamped so the exponent never drops below 1.
  always_comb begin
    w_lz = '0;
    for (int i = 0; i < MAN_W - 1; i++) begin
      if (r_man[i]) w_lz = EW'(MAN_W - 2 - i);
    end
    w_sh = (w_lz < (r_exp - EXP_ONE)) ? w_lz : (r_exp - EXP_ONE);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sub    <= 1'b0;
      r_sign   <= 1'b0;
      r_great  <= '0;
      r_small  <= '0;
      r_man    <= '0;
      r_exp    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (bus.is_special) begin
              r_result <= bus.special_result;
              r_ovf    <= 1'b0;
              r_unf    <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              r_sub   <= bus.op_sub;
              r_sign  <= bus.sign_in;
              r_great <= bus.mantis_great;
              r_small <= bus.mantis_small;
              r_exp   <= (bus.exp == '0) ? EXP_ONE : {2'b00, bus.exp};
              r_state <= S_SUM;
            end
          end
        end
        S_SUM: begin
          r_man   <= r_sub ? (r_great - r_small) : (r_great + r_small);
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_man == '0) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_state  <= S_DONE;
          end else if (r_man[MAN_W-1]) begin
            r_man   <= {1'b0, r_man[MAN_W-1:2], r_man[1] | r_man[0]};
            r_exp   <= r_exp + EXP_ONE;
            r_state <= S_ROUND;
          end
`ifdef LZC_NORM_EN
          else begin
            r_man   <= r_man << w_sh;
            r_exp   <= r_exp - w_sh;
            r_state <= S_ROUND;
          end
`else
          else if (!r_man[MAN_W-2] && (r_exp > EXP_ONE)) begin
            r_man <= {r_man[MAN_W-2:0], 1'b0};
            r_exp <= r_exp - EXP_ONE;
          end else begin
            r_state <= S_ROUND;
          end
`endif
        end
        S_ROUND: begin
          r_state <= S_DONE;
          if (w_exp_rnd >= EXP_INF) begin
            r_result <= {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            r_ovf    <= 1'b1;
            r_unf    <= 1'b0;
          end else begin
            r_result <= {r_sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd};
            r_ovf    <= 1'b0;
            r_unf    <= (w_exp_rnd == '0);
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
endmodule
